// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the fetch state encoding.
package cpu_pkg;
  localparam int ADDR_W = 11;
  localparam int INST_W = 9;
  localparam int unsigned START_ADDR = 0;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int              ADDR_W  = 11,
  parameter logic [ADDR_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= RST_VAL;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + ADDR_W'(1);
  end
endmodule

// File: rtl/inst_fetch.sv
// PC + instruction register stage in front of the instruction ROM.
// Optional: INST_FETCH_CYCLE_CNT_EN adds a saturating 16-bit RUN-cycle counter.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int          ADDR_W     = cpu_pkg::ADDR_W,
  parameter int          INST_W     = cpu_pkg::INST_W,
  parameter int unsigned START_ADDR = cpu_pkg::START_ADDR
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [INST_W-1:0] InstIn,
  input  logic              Stall,
  input  logic              Branch,
  input  logic [ADDR_W-1:0] Target,
  input  logic              Halt,
  output logic [ADDR_W-1:0] InstAddress,
  output logic [INST_W-1:0] InstOut,
  output logic [ADDR_W-1:0] InstPC,
  output logic              InstValid,
  output logic              Done
`ifdef INST_FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]       CycleCount
`endif
);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  fetch_state_e      state_q, state_d;
  logic              pc_load, pc_inc, ir_load, valid_d;
  logic [ADDR_W-1:0] pc_load_val, pc;

  pc_reg #(.ADDR_W(ADDR_W), .RST_VAL(START_PC)) u_pc (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_load_val = START_PC;
    pc_inc      = 1'b0;
    ir_load     = 1'b0;
    valid_d     = InstValid;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_load = 1'b1;
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (Branch) begin
          // wrong-path word on InstIn this cycle is dropped: one bubble
          pc_load     = 1'b1;
          pc_load_val = Target;
          valid_d     = 1'b0;
        end else if (!Stall) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      InstOut   <= '0;
      InstPC    <= '0;
      InstValid <= 1'b0;
    end else begin
      state_q   <= state_d;
      InstValid <= valid_d;
      if (ir_load) begin
        InstOut <= InstIn;
        InstPC  <= pc;
      end
    end
  end

  assign InstAddress = pc;
  assign Done        = (state_q == HALTED);

`ifdef INST_FETCH_CYCLE_CNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                               CycleCount <= '0;
    else if (state_q != RUN && Start)         CycleCount <= '0;
    else if (state_q == RUN && CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: behavioural fetch model checked every cycle plus literal checkpoints.
module tb_inst_fetch;
  localparam int AW = 11;
  localparam int IW = 9;

  logic          Clk = 1'b0;
  logic          Reset, Start, Stall, Branch, Halt;
  logic [AW-1:0] Target;
  logic [IW-1:0] InstIn;
  logic [AW-1:0] InstAddress, InstPC;
  logic [IW-1:0] InstOut;
  logic          InstValid, Done;
`ifdef INST_FETCH_CYCLE_CNT_EN
  logic [15:0]   CycleCount;
`endif

  logic [IW-1:0] rom [0:2047];
  assign InstIn = rom[InstAddress];

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstIn(InstIn), .Stall(Stall),
    .Branch(Branch), .Target(Target), .Halt(Halt), .InstAddress(InstAddress),
    .InstOut(InstOut), .InstPC(InstPC), .InstValid(InstValid), .Done(Done)
`ifdef INST_FETCH_CYCLE_CNT_EN
    , .CycleCount(CycleCount)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0=idle 1=run 2=halted, stepped straight from the fetch rules
  int          m_st;
  int unsigned m_pc, m_out, m_opc, m_cnt;
  bit          m_valid;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_st <= 0; m_pc <= 0; m_out <= 0; m_opc <= 0; m_valid <= 0; m_cnt <= 0;
    end else begin
      case (m_st)
        1: begin
          m_cnt <= (m_cnt == 65535) ? 65535 : m_cnt + 1;
          if (Halt) begin
            m_st <= 2; m_valid <= 0;
          end else if (Branch) begin
            m_pc <= Target; m_valid <= 0;
          end else if (!Stall) begin
            m_out <= rom[m_pc]; m_opc <= m_pc; m_valid <= 1;
            m_pc <= (m_pc + 1) % 2048;
          end
        end
        default: if (Start) begin m_st <= 1; m_pc <= 0; m_cnt <= 0; end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (checking) begin
      chk("m_addr",  32'(InstAddress), m_pc);
      chk("m_out",   32'(InstOut),     m_out);
      chk("m_pc",    32'(InstPC),      m_opc);
      chk("m_valid", 32'(InstValid),   32'(m_valid));
      chk("m_done",  32'(Done),        32'(m_st == 2));
`ifdef INST_FETCH_CYCLE_CNT_EN
      chk("m_cnt",   32'(CycleCount),  m_cnt);
`endif
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = IW'((a * 37 + 5) ^ (a >> 3));
    rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h044;
    rom[11'h100] = 9'h1A5; rom[2046] = 9'h0EE; rom[2047] = 9'h0FF;

    Reset = 1'b0; Start = 0; Stall = 0; Branch = 0; Halt = 0; Target = '0;
    #2 checking = 1'b1;
    step(2);
    Reset = 1'b1;
    step(4);
    chk("idle_pc", 32'(InstAddress), 0);
    chk("idle_valid", 32'(InstValid), 0);
    chk("idle_done", 32'(Done), 0);

    Start = 1; step(); Start = 0;
    chk("start_valid", 32'(InstValid), 0);
    step(); chk("f0_out", 32'(InstOut), 32'h011); chk("f0_valid", 32'(InstValid), 1);
    step(); chk("f1_out", 32'(InstOut), 32'h022); chk("f1_pc", 32'(InstPC), 1);

    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out", 32'(InstOut), 32'h022);
      chk("stall_ipc", 32'(InstPC), 1);
      chk("stall_addr", 32'(InstAddress), 2);
    end
    Stall = 0;
    step(); chk("f2_out", 32'(InstOut), 32'h033);
    step(); chk("f3_out", 32'(InstOut), 32'h044); chk("f3_pc", 32'(InstPC), 3);

    Halt = 1; step(); Halt = 0;
    chk("halt_done", 32'(Done), 1); chk("halt_valid", 32'(InstValid), 0);
    chk("halt_out_hold", 32'(InstOut), 32'h044);
    step(2); chk("halted_done", 32'(Done), 1);

    Start = 1; step(); Start = 0;
    chk("restart_done", 32'(Done), 0); chk("restart_addr", 32'(InstAddress), 0);
    step(); chk("r0_out", 32'(InstOut), 32'h011);
    step(); chk("r1_out", 32'(InstOut), 32'h022);

    // branch together with stall: branch wins
    Branch = 1; Stall = 1; Target = 11'h100; step(); Branch = 0; Stall = 0;
    chk("br_bubble", 32'(InstValid), 0); chk("br_addr", 32'(InstAddress), 32'h100);
    step(); chk("br_out", 32'(InstOut), 32'h1A5); chk("br_ipc", 32'(InstPC), 32'h100);
    chk("br_valid", 32'(InstValid), 1);

    Start = 1; step(); Start = 0;
    chk("start_in_run", 32'(InstPC), 32'h101);

    Branch = 1; Target = 11'd2046; step(); Branch = 0;
    step(); chk("w0_out", 32'(InstOut), 32'h0EE); chk("w0_ipc", 32'(InstPC), 2046);
    step(); chk("w1_ipc", 32'(InstPC), 2047); chk("wrap_addr", 32'(InstAddress), 0);
    step(); chk("w2_out", 32'(InstOut), 32'h011); chk("w2_ipc", 32'(InstPC), 0);

    Halt = 1; Branch = 1; Target = 11'h055; step(); Halt = 0; Branch = 0;
    chk("hb_done", 32'(Done), 1); chk("hb_addr", 32'(InstAddress), 1);

    Start = 1; step(); Start = 0;
    step(2); chk("pre_rst_out", 32'(InstOut), 32'h022);

    @(posedge Clk); #3 Reset = 1'b0;
    #1;
    chk("rst_addr", 32'(InstAddress), 0); chk("rst_out", 32'(InstOut), 0);
    chk("rst_ipc", 32'(InstPC), 0); chk("rst_valid", 32'(InstValid), 0);
    chk("rst_done", 32'(Done), 0);
    step(2);
    Reset = 1'b1;
    step(3);
    chk("post_rst_addr", 32'(InstAddress), 0); chk("post_rst_valid", 32'(InstValid), 0);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
